dram_master: RTL

DRAM_MASTER -- requirements
Module: dram_master

---
 rtl/ds_pkg.sv | 16 +
 rtl/ds_addr_gen.sv | 27 ++
 rtl/dram_master.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ds_pkg.sv
// Shared types for the 2x2 image downsampler: FSM state encoding and default output base address.
package ds_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RD_ADDR,
        S_RD_DATA,
        S_WRITE,
        S_SAVE,
        S_DONE
    } state_t;

    localparam logic [15:0] DEF_OUT_BASE = 16'h8000;

endpackage

// File: rtl/ds_addr_gen.sv
// Combinational address generator: maps output pixel (r, c) and tap k to the source read address
// and the destination write address. Zero latency, no flow control.
module ds_addr_gen #(
    parameter int          IMG_W    = 128,
    parameter logic [15:0] OUT_BASE = 16'h8000,
    parameter int          CW       = $clog2(IMG_W)
) (
    input  logic [CW-1:0] r_i,
    input  logic [CW-1:0] c_i,
    input  logic [1:0]    k_i,
    output logic [15:0]   rd_addr_o,
    output logic [15:0]   wr_addr_o
);

    localparam logic [15:0] SRC_W = 16'(IMG_W);
    localparam logic [15:0] DST_W = 16'(IMG_W / 2);

    logic [15:0] src_row;
    logic [15:0] src_col;

    // k[1] selects the lower row of the 2x2 block, k[0] the right column.
    assign src_row   = (16'(r_i) << 1) | 16'(k_i[1]);
    assign src_col   = (16'(c_i) << 1) | 16'(k_i[0]);
    assign rd_addr_o = src_row * SRC_W + src_col;
    assign wr_addr_o = OUT_BASE + 16'(r_i) * DST_W + 16'(c_i);

endmodule

// File: rtl/dram_master.sv
// 2x2 box-filter downsampler: loads an image, reads four taps per output pixel and writes their average.
// Nine cycles per output pixel; waits indefinitely on dram_rd_done / dram_wr_done handshakes.
module dram_master
    import ds_pkg::*;
#(
    parameter int          IMG_W    = 128,
    parameter logic [15:0] OUT_BASE = DEF_OUT_BASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        dram_rd_en,
    input  logic        dram_rd_done,
    output logic        dram_read,
    output logic        dram_write,
    output logic [15:0] dram_addr,
    output logic [7:0]  dram_din,
    input  logic [7:0]  dram_dout,
    output logic        dram_wr_en,
    input  logic        dram_wr_done
);

    localparam int            CW   = $clog2(IMG_W);
    localparam logic [CW-1:0] LAST = CW'(IMG_W / 2 - 1);

    state_t        state_q;
    logic [CW-1:0] r_q;
    logic [CW-1:0] c_q;
    logic [1:0]    k_q;
    logic [9:0]    sum_q;

    logic          busy_q;
    logic          done_q;
    logic          rd_en_q;
    logic          wr_en_q;
    logic          read_q;
    logic          write_q;
    logic [15:0]   addr_q;
    logic [7:0]    din_q;

    logic          c_last;
    logic          pix_last;
    logic [CW-1:0] r_d;
    logic [CW-1:0] c_d;
    logic [CW-1:0] ag_r;
    logic [CW-1:0] ag_c;
    logic [1:0]    ag_k;
    logic [9:0]    sum_d;
    logic [15:0]   rd_addr;
    logic [15:0]   wr_addr;

    // Outputs are registered, so the generator is fed the coordinates of the cycle being entered.
    always_comb begin
        c_last   = (c_q == LAST);
        pix_last = c_last && (r_q == LAST);
        c_d      = c_last ? '0 : c_q + 1'b1;
        r_d      = c_last ? r_q + 1'b1 : r_q;
        sum_d    = sum_q + {2'b00, dram_dout};
        ag_r     = r_q;
        ag_c     = c_q;
        ag_k     = '0;
        case (state_q)
            S_LOAD: begin
                ag_r = '0;
                ag_c = '0;
            end
            S_RD_DATA: ag_k = k_q + 1'b1;
            S_WRITE: begin
                ag_r = r_d;
                ag_c = c_d;
            end
            default: ;
        endcase
    end

    ds_addr_gen #(
        .IMG_W    (IMG_W),
        .OUT_BASE (OUT_BASE),
        .CW       (CW)
    ) u_addr_gen (
        .r_i       (ag_r),
        .c_i       (ag_c),
        .k_i       (ag_k),
        .rd_addr_o (rd_addr),
        .wr_addr_o (wr_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (dram_rd_done) begin
                        state_q <= S_RD_ADDR;
                        rd_en_q <= 1'b0;
                        r_q     <= '0;
                        c_q     <= '0;
                        k_q     <= '0;
                        sum_q   <= '0;
                        read_q  <= 1'b1;
                        addr_q  <= rd_addr;
                    end
                end
                S_RD_ADDR: state_q <= S_RD_DATA;
                S_RD_DATA: begin
                    sum_q <= sum_d;
                    if (k_q == 2'd3) begin
                        state_q <= S_WRITE;
                        write_q <= 1'b1;
                        addr_q  <= wr_addr;
                        din_q   <= sum_d[9:2];
                    end else begin
                        state_q <= S_RD_ADDR;
                        k_q     <= k_q + 1'b1;
                        read_q  <= 1'b1;
                        addr_q  <= rd_addr;
                    end
                end
                S_WRITE: begin
                    k_q   <= '0;
                    sum_q <= '0;
                    if (pix_last) begin
                        state_q <= S_SAVE;
                        wr_en_q <= 1'b1;
                        r_q     <= '0;
                        c_q     <= '0;
                    end else begin
                        state_q <= S_RD_ADDR;
                        r_q     <= r_d;
                        c_q     <= c_d;
                        read_q  <= 1'b1;
                        addr_q  <= rd_addr;
                    end
                end
                S_SAVE: begin
                    if (dram_wr_done) begin
                        state_q <= S_DONE;
                        wr_en_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign dram_rd_en = rd_en_q;
    assign dram_wr_en = wr_en_q;
    assign dram_read  = read_q;
    assign dram_write = write_q;
    assign dram_addr  = addr_q;
    assign dram_din   = din_q;

endmodule
